// File: rtl/hash_pkg.sv
// Shared widths, the result tag carried alongside the hash core, and the key length check.
package hash_pkg;

  localparam int HASH_KEY_W   = 96;
  localparam int HASH_LEN_W   = 8;
  localparam int HASH_OUT_W   = 32;
  localparam int HASH_MAX_LEN = 12;
  localparam int HASH_WORD_W  = HASH_KEY_W / 3;
  localparam int HASH_IDX_W   = 3;

  typedef struct packed {
    logic                  valid;
    logic [HASH_IDX_W-1:0] idx;
    logic                  err;
  } hash_tag_t;

  // lookup3 single-block keys must hold 1..12 bytes
  function automatic logic hash_len_err(input logic [HASH_LEN_W-1:0] len);
    return (len == '0) || (len > HASH_LEN_W'(HASH_MAX_LEN));
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: search starts one past the last granted index; pointer moves only on advance.
module rr_arbiter #(
  parameter int unsigned NREQ = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NREQ-1:0]         req,
  input  logic                    advance,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] gnt_idx
);

  localparam int unsigned IW = $clog2(NREQ);

  logic [IW-1:0] last;
  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    cand    = '0;
    found   = 1'b0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      cand = IW'((32'(last) + off) % NREQ);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      last <= IW'(NREQ - 1);
    end else if (advance) begin
      last <= gnt_idx;
    end
  end

endmodule

// File: rtl/hash_arbiter.sv
// Shares one fixed-latency lookup3 core among NREQ requesters and routes each result back.
// Optional per-requester grant statistics: define HASH_ARB_STATS_EN.
module hash_arbiter
  import hash_pkg::*;
#(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned HASH_LAT = 3
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       enable,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*HASH_LEN_W-1:0] req_key_length,
  input  logic [NREQ*HASH_KEY_W-1:0] req_k,
  output logic                       core_valid,
  output logic [HASH_LEN_W-1:0]      core_key_length,
  output logic [HASH_WORD_W-1:0]     core_k0,
  output logic [HASH_WORD_W-1:0]     core_k1,
  output logic [HASH_WORD_W-1:0]     core_k2,
  input  logic [HASH_OUT_W-1:0]      core_hashkey,
  output logic [NREQ-1:0]            res_valid,
  output logic [HASH_OUT_W-1:0]      res_hashkey,
  output logic                       res_err,
  output logic                       busy
`ifdef HASH_ARB_STATS_EN
  ,
  input  logic [2:0]                 stat_sel,
  output logic [15:0]                stat_count
`endif
);

  localparam int unsigned IW = $clog2(NREQ);

  logic [NREQ-1:0]       arb_req;
  logic [NREQ-1:0]       gnt;
  logic [IW-1:0]         gnt_idx;
  logic                  xfer;
  logic [HASH_LEN_W-1:0] sel_len;
  logic [HASH_KEY_W-1:0] sel_k;
  hash_tag_t             tag_q [HASH_LAT+1];
  hash_tag_t             ret;

  assign arb_req = req_valid & {NREQ{enable & ~RST}};

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .CLK     (CLK),
    .RST     (RST),
    .req     (arb_req),
    .advance (xfer),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign xfer      = |gnt;
  assign sel_len   = req_key_length[gnt_idx*HASH_LEN_W +: HASH_LEN_W];
  assign sel_k     = req_k[gnt_idx*HASH_KEY_W +: HASH_KEY_W];

  always_ff @(posedge CLK) begin
    if (RST) begin
      core_key_length <= '0;
      core_k0         <= '0;
      core_k1         <= '0;
      core_k2         <= '0;
    end else if (xfer) begin
      core_key_length             <= sel_len;
      {core_k0, core_k1, core_k2} <= sel_k;
    end
  end

  // Stage 0 of the tag pipe doubles as core_valid; stage HASH_LAT lines up with core_hashkey.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned s = 0; s <= HASH_LAT; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      tag_q[0] <= '{valid: xfer, idx: HASH_IDX_W'(gnt_idx), err: xfer & hash_len_err(sel_len)};
      for (int unsigned s = 1; s <= HASH_LAT; s++) begin
        tag_q[s] <= tag_q[s-1];
      end
    end
  end

  assign core_valid = tag_q[0].valid;
  assign ret        = tag_q[HASH_LAT];

  always_ff @(posedge CLK) begin
    if (RST) begin
      res_valid   <= '0;
      res_hashkey <= '0;
      res_err     <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        res_valid[i] <= ret.valid && (ret.idx == HASH_IDX_W'(i));
      end
      if (ret.valid) begin
        res_hashkey <= core_hashkey;
        res_err     <= ret.err;
      end
    end
  end

  always_comb begin
    busy = xfer | (|res_valid);
    for (int unsigned s = 0; s <= HASH_LAT; s++) begin
      busy = busy | tag_q[s].valid;
    end
  end

`ifdef HASH_ARB_STATS_EN
  logic [15:0] grant_cnt [NREQ];
  logic [15:0] stat_mux;

  always_comb begin
    stat_mux = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (stat_sel == 3'(i)) stat_mux = grant_cnt[i];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        grant_cnt[i] <= '0;
      end
      stat_count <= '0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (gnt[i] && grant_cnt[i] != '1) grant_cnt[i] <= grant_cnt[i] + 16'd1;
      end
      stat_count <= stat_mux;
    end
  end
`endif

endmodule

// File: tb/tb_hash_arbiter.sv
// Directed bench for hash_arbiter with a lookup3-final core model and a result scoreboard.
module tb_hash_arbiter;

  localparam int unsigned NREQ     = 4;
  localparam int unsigned HASH_LAT = 3;

  logic                 CLK = 1'b0;
  logic                 RST = 1'b1;
  logic                 enable = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*8-1:0]    req_key_length = '0;
  logic [NREQ*96-1:0]   req_k = '0;
  logic                 core_valid;
  logic [7:0]           core_key_length;
  logic [31:0]          core_k0, core_k1, core_k2;
  logic [31:0]          core_hashkey;
  logic [NREQ-1:0]      res_valid;
  logic [31:0]          res_hashkey;
  logic                 res_err;
  logic                 busy;
`ifdef HASH_ARB_STATS_EN
  logic [2:0]           stat_sel = '0;
  logic [15:0]          stat_count;
`endif

  hash_arbiter #(.NREQ(NREQ), .HASH_LAT(HASH_LAT)) dut (
    .CLK             (CLK),
    .RST             (RST),
    .enable          (enable),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_key_length  (req_key_length),
    .req_k           (req_k),
    .core_valid      (core_valid),
    .core_key_length (core_key_length),
    .core_k0         (core_k0),
    .core_k1         (core_k1),
    .core_k2         (core_k2),
    .core_hashkey    (core_hashkey),
    .res_valid       (res_valid),
    .res_hashkey     (res_hashkey),
    .res_err         (res_err),
    .busy            (busy)
`ifdef HASH_ARB_STATS_EN
    ,
    .stat_sel        (stat_sel),
    .stat_count      (stat_count)
`endif
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rotl(input logic [31:0] x, input int k);
    return (x << k) | (x >> (32 - k));
  endfunction

  // lookup3 init + final() on a single three-word block
  function automatic logic [31:0] lookup3(input logic [7:0] len, input logic [31:0] k0,
                                          input logic [31:0] k1, input logic [31:0] k2);
    logic [31:0] a, b, c;
    a = 32'hdeadbeef + {24'd0, len};
    b = a;
    c = a;
    a += k0; b += k1; c += k2;
    c ^= b; c -= rotl(b, 14);
    a ^= c; a -= rotl(c, 11);
    b ^= a; b -= rotl(a, 25);
    c ^= b; c -= rotl(b, 16);
    a ^= c; a -= rotl(c, 4);
    b ^= a; b -= rotl(a, 14);
    c ^= b; c -= rotl(b, 24);
    return c;
  endfunction

  // Core model: garbage on idle cycles so a misaligned capture shows up
  logic [31:0] core_pipe [HASH_LAT];
  assign core_hashkey = core_pipe[HASH_LAT-1];
  always @(posedge CLK) begin
    core_pipe[0] <= core_valid ? lookup3(core_key_length, core_k0, core_k1, core_k2)
                               : {16'hbad0, cyc[15:0]};
    for (int s = 1; s < HASH_LAT; s++) core_pipe[s] <= core_pipe[s-1];
  end

  typedef struct {
    int          due;
    int          idx;
    logic [31:0] hash;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   pulses = 0;
  int   pulse_cnt [NREQ];
  int   rr_exp [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

  initial for (int i = 0; i < NREQ; i++) pulse_cnt[i] = 0;

  always @(negedge CLK) begin
    exp_t        e;
    logic [7:0]  len;
    logic [95:0] kk;
    if (req_ready != '0) begin
      check("ready_onehot", $countones(req_ready), 1);
      check("ready_subset", {28'd0, req_ready & ~req_valid}, 0);
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i] && req_valid[i]) begin
          len    = req_key_length[i*8 +: 8];
          kk     = req_k[i*96 +: 96];
          e.due  = cyc + HASH_LAT + 2;
          e.idx  = i;
          e.hash = lookup3(len, kk[95:64], kk[63:32], kk[31:0]);
          e.err  = (len == 8'd0) || (len > 8'd12);
          q.push_back(e);
        end
      end
    end
    if (res_valid != '0) begin
      pulses++;
      if (q.size() == 0) begin
        check("res_unexpected", {28'd0, res_valid}, 0);
      end else begin
        e = q.pop_front();
        check("res_cycle", cyc, e.due);
        check("res_route", {28'd0, res_valid}, 1 << e.idx);
        check("res_hash", res_hashkey, e.hash);
        check("res_err", {31'd0, res_err}, {31'd0, e.err});
        pulse_cnt[e.idx]++;
      end
    end else if (q.size() != 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      check("res_missing", {28'd0, res_valid}, 1 << e.idx);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic look();
    @(negedge CLK);
  endtask

  task automatic set_key(input int i, input logic [7:0] len, input logic [31:0] k0,
                         input logic [31:0] k1, input logic [31:0] k2);
    req_key_length[i*8 +: 8] = len;
    req_k[i*96 +: 96]        = {k0, k1, k2};
  endtask

  task automatic do_reset();
    tick();
    RST = 1'b1; req_valid = '1; enable = 1'b1;
    q.delete();
    look();
    check("rst_ready0", {28'd0, req_ready}, 0);
    tick();
    look();
    check("rst_ready1", {28'd0, req_ready}, 0);
    check("rst_core_valid", {31'd0, core_valid}, 0);
    check("rst_res_valid", {28'd0, res_valid}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_res_err", {31'd0, res_err}, 0);
    check("rst_res_hash", res_hashkey, 0);
    check("rst_core_len", {24'd0, core_key_length}, 0);
    check("rst_core_k0", core_k0, 0);
    tick();
    RST = 1'b0; req_valid = '0;
  endtask

  task automatic drain();
    int n = 0;
    look();
    while ((busy !== 1'b0 || q.size() != 0) && n < 40) begin
      tick();
      look();
      n++;
    end
    check("drain", {31'd0, busy !== 1'b0 || q.size() != 0}, 0);
  endtask

  // Little-endian words of "abcd","efgh","ijkl"
  task automatic single(input logic [7:0] len, input logic e);
    int t0;
    tick();
    set_key(0, len, 32'h64636261, 32'h68676665, 32'h6c6b6a69);
    req_valid = 4'b0001; enable = 1'b1;
    look();
    check("s_ready", {28'd0, req_ready}, 1);
    check("s_busy_xfer", {31'd0, busy}, 1);
    t0 = cyc;
    tick();
    req_valid = '0;
    look();
    check("s_core_valid", {31'd0, core_valid}, 1);
    check("s_core_len", {24'd0, core_key_length}, {24'd0, len});
    check("s_core_k0", core_k0, 32'h64636261);
    check("s_core_k2", core_k2, 32'h6c6b6a69);
    while (cyc < t0 + HASH_LAT + 1) begin
      tick();
      look();
    end
    check("s_res_early", {28'd0, res_valid}, 0);
    check("s_busy_mid", {31'd0, busy}, 1);
    tick();
    look();
    check("s_res_valid", {28'd0, res_valid}, 1);
    check("s_res_err", {31'd0, res_err}, {31'd0, e});
    check("s_res_hash", res_hashkey, lookup3(len, 32'h64636261, 32'h68676665, 32'h6c6b6a69));
    check("s_busy_last", {31'd0, busy}, 1);
    tick();
    look();
    check("s_res_off", {28'd0, res_valid}, 0);
    check("s_busy_off", {31'd0, busy}, 0);
    check("s_err_hold", {31'd0, res_err}, {31'd0, e});
    check("s_hash_hold", res_hashkey, lookup3(len, 32'h64636261, 32'h68676665, 32'h6c6b6a69));
  endtask

  initial begin
    int base [NREQ];
    int p, tb, sent, n;

    do_reset();

    single(8'd13, 1'b1);
    single(8'd12, 1'b0);
    single(8'd0, 1'b1);

    // Round robin with all requesters active
    do_reset();
    tick();
    for (int i = 0; i < NREQ; i++)
      set_key(i, 8'(4 + i), 32'(32'h11111111 * (i + 1)), 32'(32'h01020304 + i), 32'(32'hcafe0000 + i));
    for (int i = 0; i < NREQ; i++) base[i] = pulse_cnt[i];
    req_valid = '1; enable = 1'b1;
    for (int k = 0; k < 8; k++) begin
      look();
      check("rr_grant", {28'd0, req_ready}, 1 << rr_exp[k]);
      if (k < 7) tick();
    end
    tick();
    req_valid = '0;
    drain();
    for (int i = 0; i < NREQ; i++) check("rr_routed", pulse_cnt[i] - base[i], 2);

    // Enable dropped after two grants
    tick();
    req_valid = '1; enable = 1'b1;
    look();
    check("en_g0", {28'd0, req_ready}, 4'b0001);
    tick();
    look();
    check("en_g1", {28'd0, req_ready}, 4'b0010);
    tb = cyc;
    tick();
    enable = 1'b0;
    p = pulses;
    look();
    check("en_ready_off", {28'd0, req_ready}, 0);
    check("en_busy", {31'd0, busy}, 1);
    while (cyc < tb + HASH_LAT + 2) begin
      tick();
      look();
      check("en_ready_off", {28'd0, req_ready}, 0);
    end
    check("en_res_last", {28'd0, res_valid}, 4'b0010);
    check("en_busy_last", {31'd0, busy}, 1);
    tick();
    look();
    check("en_busy_fall", {31'd0, busy}, 0);
    check("en_two_results", pulses - p, 2);
    tick();
    enable = 1'b1;
    look();
    check("en_resume", {28'd0, req_ready}, 4'b0100);
    tick();
    req_valid = '0;
    drain();

    // Reset with three requests in flight
    tick();
    req_valid = 4'b0111; enable = 1'b1;
    look();
    check("rf_g0", {28'd0, req_ready}, 4'b0001);
    tick();
    look();
    check("rf_g1", {28'd0, req_ready}, 4'b0010);
    tick();
    look();
    check("rf_g2", {28'd0, req_ready}, 4'b0100);
    p = pulses;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      look();
      check("rf_busy", {31'd0, busy}, 0);
      tick();
    end
    check("rf_no_pulse", pulses - p, 0);
    req_valid = '1;
    look();
    check("rf_first_grant", {28'd0, req_ready}, 4'b0001);
    tick();
    req_valid = '0;
    drain();

    // Sole requester granted back to back
    do_reset();
    tick();
    set_key(2, 8'd7, 32'h2, 32'h22, 32'h222);
    req_valid = 4'b0100; enable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      look();
      check("sole_grant", {28'd0, req_ready}, 4'b0100);
      tick();
    end
    req_valid = '0;
`ifdef HASH_ARB_STATS_EN
    stat_sel = 3'd2;
    tick();
    tick();
    look();
    check("stat_cnt2", {16'd0, stat_count}, 5);
    stat_sel = 3'd0;
    tick();
    look();
    check("stat_cnt0", {16'd0, stat_count}, 0);
`endif
    drain();

    // Random traffic with grants and retirements overlapping
    p = pulses; sent = 0; n = 0;
    while (sent < 100 && n < 3000) begin
      tick();
      req_valid = NREQ'($urandom_range(0, 15));
      enable    = ($urandom_range(0, 7) != 0);
      for (int i = 0; i < NREQ; i++)
        set_key(i, 8'($urandom_range(0, 15)), $urandom, $urandom, $urandom);
      look();
      if ((req_valid & req_ready) != '0) sent++;
      n++;
    end
    tick();
    req_valid = '0;
    drain();
    check("rand_sent", sent, 100);
    check("rand_pulses", pulses - p, 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1);
  end

endmodule
